// File: rtl/multicycle_core_if.sv
// Instruction handshake bundle for multicycle_core: offer/accept of one
// instruction word plus the per-instruction retire strobe and error flag.
interface multicycle_core_if #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_BITS   = 2
);
    localparam int INSTR_WIDTH = 2 + 3 * REG_BITS + DATA_WIDTH + 4;

    logic                   instr_valid;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_ready;
    logic                   done;
    logic                   err;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready,
        input  done,
        input  err
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready,
        output done,
        output err
    );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle execution core: register file, 8-op ALU, data memory and a
// 5-state control FSM. Optional ALU_FLAGS_EN adds zero_flag / carry_flag outputs.
module multicycle_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5,
    parameter int REG_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_core_if.slave      bus,
    input  logic [REG_BITS-1:0]   dbg_sel,
    output logic [DATA_WIDTH-1:0] dbg_data
`ifdef ALU_FLAGS_EN
    ,
    output logic                  zero_flag,
    output logic                  carry_flag
`endif
);
    localparam int INSTR_WIDTH = 2 + 3 * REG_BITS + DATA_WIDTH + 4;
    localparam int NUM_REGS    = 2 ** REG_BITS;
    localparam int MEM_WORDS   = 2 ** ADDR_BITS;
    localparam int SH_BITS     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [1:0] T_NOP   = 2'b00;
    localparam logic [1:0] T_STD   = 2'b01;
    localparam logic [1:0] T_LOAD  = 2'b10;
    localparam logic [1:0] T_STORE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [INSTR_WIDTH-1:0] instr_r;
    logic [DATA_WIDTH-1:0]  reg_file_r [NUM_REGS];
    logic [DATA_WIDTH-1:0]  mem_r      [MEM_WORDS];
    logic [DATA_WIDTH-1:0]  rs1_val_r;
    logic [DATA_WIDTH-1:0]  rs2_val_r;
    logic [DATA_WIDTH-1:0]  rd_val_r;
    logic [DATA_WIDTH-1:0]  result_r;
    logic                   carry_r;
    logic [ADDR_BITS-1:0]   addr_r;
    logic                   ready_r;
    logic                   done_r;
    logic                   err_r;

    logic [1:0]             type_s;
    logic [REG_BITS-1:0]    rd_s;
    logic [REG_BITS-1:0]    rs1_s;
    logic [REG_BITS-1:0]    rs2_s;
    logic [DATA_WIDTH-1:0]  offset_s;
    logic [3:0]             opcode_s;
    logic [DATA_WIDTH-1:0]  alu_s;
    logic                   carry_s;
    logic                   illegal_s;
    logic [ADDR_BITS-1:0]   addr_s;

    assign type_s   = instr_r[INSTR_WIDTH-1 -: 2];
    assign rd_s     = instr_r[INSTR_WIDTH-3 -: REG_BITS];
    assign rs1_s    = instr_r[INSTR_WIDTH-3-REG_BITS -: REG_BITS];
    assign rs2_s    = instr_r[INSTR_WIDTH-3-2*REG_BITS -: REG_BITS];
    assign offset_s = instr_r[DATA_WIDTH+3 -: DATA_WIDTH];
    assign opcode_s = instr_r[3:0];

    // Address is the low ADDR_BITS of the wrapped DATA_WIDTH-bit sum.
    assign addr_s = ADDR_BITS'(rs1_val_r + offset_s);

    // Next-state selection for the control FSM.
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (type_s == T_NOP) begin
                    next_state_s = ST_WB;
                end else begin
                    next_state_s = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (type_s == T_STD) begin
                    next_state_s = ST_WB;
                end else begin
                    next_state_s = ST_MEM;
                end
            end
            ST_MEM:  next_state_s = ST_WB;
            ST_WB:   next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // ALU on the operands latched in DECODE; illegal opcodes yield zero.
    always_comb begin
        alu_s     = '0;
        carry_s   = 1'b0;
        illegal_s = 1'b0;
        case (opcode_s)
            4'd0: {carry_s, alu_s} = {1'b0, rs1_val_r} + {1'b0, rs2_val_r};
            4'd1: begin
                alu_s   = rs1_val_r - rs2_val_r;
                carry_s = (rs1_val_r < rs2_val_r);
            end
            4'd2: alu_s = rs1_val_r & rs2_val_r;
            4'd3: alu_s = rs1_val_r | rs2_val_r;
            4'd4: alu_s = rs1_val_r ^ rs2_val_r;
            4'd5: alu_s = rs1_val_r << rs2_val_r[SH_BITS-1:0];
            4'd6: alu_s = rs1_val_r >> rs2_val_r[SH_BITS-1:0];
            4'd7: alu_s = rs2_val_r;
            default: illegal_s = 1'b1;
        endcase
    end

    // FSM state, datapath registers, register file and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            instr_r   <= '0;
            rs1_val_r <= '0;
            rs2_val_r <= '0;
            rd_val_r  <= '0;
            result_r  <= '0;
            carry_r   <= 1'b0;
            addr_r    <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_file_r[i] <= DATA_WIDTH'(i);
            end
`ifdef ALU_FLAGS_EN
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
`endif
        end else begin
            state_r <= next_state_s;
            ready_r <= (next_state_s == ST_IDLE);
            done_r  <= (next_state_s == ST_WB);
            case (state_r)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        instr_r <= bus.instr;
                    end
                end
                ST_DECODE: begin
                    rs1_val_r <= reg_file_r[rs1_s];
                    rs2_val_r <= reg_file_r[rs2_s];
                    rd_val_r  <= reg_file_r[rd_s];
                end
                ST_EXECUTE: begin
                    if (type_s == T_STD) begin
                        result_r <= alu_s;
                        carry_r  <= carry_s;
                        if (illegal_s) begin
                            err_r <= 1'b1;
                        end
                    end else begin
                        addr_r <= addr_s;
                    end
                end
                ST_MEM: begin
                    if (type_s == T_LOAD) begin
                        result_r <= mem_r[addr_r];
                    end
                end
                ST_WB: begin
                    if ((type_s == T_STD) || (type_s == T_LOAD)) begin
                        reg_file_r[rd_s] <= result_r;
                    end
`ifdef ALU_FLAGS_EN
                    if (type_s == T_STD) begin
                        zero_flag  <= (result_r == '0);
                        carry_flag <= carry_r;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // Data memory: no reset; stores land on the MEM edge unless rst aborts them.
    always_ff @(posedge clk) begin
        if (!rst && (state_r == ST_MEM) && (type_s == T_STORE)) begin
            mem_r[addr_r] <= rd_val_r;
        end
    end

    assign bus.instr_ready = ready_r;
    assign bus.done        = done_r;
    assign bus.err         = err_r;
    assign dbg_data        = reg_file_r[dbg_sel];
endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core: directed scenarios plus random
// instructions compared against an arithmetic reference model.
module tb_multicycle_core;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;
`ifdef ALU_FLAGS_EN
    logic       zero_flag;
    logic       carry_flag;
`endif

    multicycle_core_if #(.DATA_WIDTH(8), .REG_BITS(2)) bus ();

    multicycle_core #(.DATA_WIDTH(8), .ADDR_BITS(5), .REG_BITS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
`ifdef ALU_FLAGS_EN
        ,
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag)
`endif
    );

    always #5 clk = ~clk;

    int m_reg [4];
    int m_mem [32];
    int m_err;
    int m_zero;
    int m_carry;
    int vectors;
    int miscompares;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_alu(input int op, input int a, input int b);
        case (op)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (a << (b % 8)) % 256;
            6: return a >> (b % 8);
            7: return b;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = i;
        m_err = 0;
        m_zero = 0;
        m_carry = 0;
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            check($sformatf("%s_reg%0d", tag, i), {24'd0, dbg_data}, m_reg[i]);
        end
        check({tag, "_err"}, {31'd0, bus.err}, m_err);
`ifdef ALU_FLAGS_EN
        check({tag, "_zero"}, {31'd0, zero_flag}, m_zero);
        check({tag, "_carry"}, {31'd0, carry_flag}, m_carry);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Issue one instruction, holding instr_valid high until done is seen.
    task automatic run(input string tag, input int typ, input int rd, input int rs1,
                       input int rs2, input int off, input int op);
        int lat;
        int a;
        int b;
        int addr;
        int res;
        bit seen;
        lat = (typ == 0) ? 2 : (typ == 1) ? 3 : 4;
        a = m_reg[rs1];
        b = m_reg[rs2];
        addr = (a + off) % 32;
        case (typ)
            1: begin
                res = ref_alu(op, a, b);
                m_reg[rd] = res;
                if (op > 7) m_err = 1;
                m_zero = (res == 0) ? 1 : 0;
                m_carry = (op == 0) ? ((a + b > 255) ? 1 : 0) :
                          (op == 1) ? ((a < b) ? 1 : 0) : 0;
            end
            2: m_reg[rd] = m_mem[addr];
            3: m_mem[addr] = m_reg[rd];
            default: ;
        endcase
        check({tag, "_ready"}, {31'd0, bus.instr_ready}, 1);
        bus.instr = {2'(typ), 2'(rd), 2'(rs1), 2'(rs2), 8'(off), 4'(op)};
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr = 20'($urandom());
        seen = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus.done) begin
                check({tag, "_done_lat"}, n, lat);
                seen = 1'b1;
                bus.instr_valid = 1'b0;
                break;
            end
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 1);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, bus.done}, 0);
        check_state(tag);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        dbg_sel = 2'd0;
        model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 0;

        // Reset state
        do_reset();
        check("rst_ready", {31'd0, bus.instr_ready}, 1);
        check("rst_done", {31'd0, bus.done}, 0);
        check_state("rst");

        // ADD r1 = r2 + r3 with instr_valid held during execution
        run("add", 1, 1, 2, 3, 0, 0);
        check("add_ready_after", {31'd0, bus.instr_ready}, 1);

        // Fill the whole data memory so later loads have defined data
        for (int i = 0; i < 32; i++) run("meminit", 3, i % 4, 0, 0, i, 0);

        // Store then load through the same address
        do_reset();
        run("st10", 3, 3, 2, 0, 10, 0);
        run("ld10", 2, 0, 2, 0, 10, 0);

        // SUB with borrow, then XOR to zero
        do_reset();
        run("sub", 1, 0, 1, 3, 0, 1);
        run("xor", 1, 2, 1, 1, 0, 4);

        // Address wrap, illegal opcode, sticky err
        do_reset();
        run("stwrap", 3, 1, 3, 0, 30, 0);
        run("ldwrap", 2, 0, 3, 0, 30, 0);
        run("illegal", 1, 2, 0, 1, 0, 15);
        run("post_illegal", 1, 3, 1, 1, 0, 0);
        run("nop", 0, 1, 2, 3, 0, 9);
        do_reset();
        check_state("err_clear");

        // Random instruction stream
        for (int i = 0; i < 200; i++) begin
            int op;
            op = ($urandom_range(0, 15) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
            run("rand", $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 255), op);
        end

        // Reset during EXECUTE abandons the instruction
        run("pre_abort", 1, 1, 1, 1, 0, 1);
        @(negedge clk);
        bus.instr = {2'b01, 2'd1, 2'd2, 2'd3, 8'd0, 4'd0};
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("abort_ready", {31'd0, bus.instr_ready}, 1);
        check_state("abort");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, bus.done}, 0);
        end
        check_state("abort_late");
        run("after_abort", 1, 1, 2, 3, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
